// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Constants and helpers shared by the sram-like to AXI bridge:
//   - AXI burst, size and response encodings
//   - sram-like transfer size encodings
//   - bridge FSM state enumeration
//   - axi_wstrb(): byte-lane strobe from transfer size and address LSBs
// ---------------------------------------------------------------------------
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_1B = 3'b000;
  localparam logic [2:0] AXI_SIZE_2B = 3'b001;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] SRAM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'b01;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    BR_IDLE    = 3'd0,
    BR_RD_ADDR = 3'd1,
    BR_RD_DATA = 3'd2,
    BR_WR_REQ  = 3'd3,
    BR_WR_RESP = 3'd4
  } bridge_state_e;

  // Write data is passed unshifted, so the strobe alone selects the lanes.
  // The unused size encoding 2'b11 is treated as a full word.
  function automatic logic [3:0] axi_wstrb(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SRAM_SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SRAM_SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:        strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sramlike_axi_bridge_if.sv
// ---------------------------------------------------------------------------
// sramlike_axi_bridge_if
// Bundles the sram-like data-cache port and the five AXI channels used by
// sramlike_axi_bridge.
//   modport master : the bridge (consumes sram-like requests, drives AXI
//                    address/write channels, accepts R and B).
//   modport slave  : the environment (data cache plus AXI slave).
// Parameter ID_W sets the width of all AXI ID fields.
// ---------------------------------------------------------------------------
interface sramlike_axi_bridge_if #(
  parameter int ID_W = 4
);
  // sram-like side
  logic            data_req;
  logic            data_wr;
  logic [1:0]      data_size;
  logic [31:0]     data_addr;
  logic [31:0]     data_wdata;
  logic [31:0]     data_rdata;
  logic            data_addr_ok;
  logic            data_data_ok;

  // AR channel
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  // R channel
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  // AW channel
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  // W channel
  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  // B channel
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/sramlike_axi_bridge.sv
// ---------------------------------------------------------------------------
// sramlike_axi_bridge
// Converts single sram-like data-cache requests into single-beat AXI
// transactions, one outstanding at a time.
//
// Ports:
//   clk     : clock, all state changes on the rising edge
//   resetn  : asynchronous active-low reset
//   bus     : sramlike_axi_bridge_if.master (sram-like port + AR/R/AW/W/B)
//
// Parameters:
//   ID_W  : AXI ID width
//   RD_ID : ARID driven on reads
//   WR_ID : AWID/WID driven on writes
//
// Build option:
//   SRAMLIKE_AXI_WR_EARLY_OK_EN : when defined, a write acknowledges
//   (data_data_ok) on the cycle its AW and W handshakes have both finished,
//   instead of on the B response. The FSM still waits for B before
//   accepting the next request.
// ---------------------------------------------------------------------------
module sramlike_axi_bridge
  import axi_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int RD_ID = 0,
  parameter int WR_ID = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  sramlike_axi_bridge_if.master bus
);

  localparam logic [2:0] S_IDLE    = BR_IDLE;
  localparam logic [2:0] S_RD_ADDR = BR_RD_ADDR;
  localparam logic [2:0] S_RD_DATA = BR_RD_DATA;
  localparam logic [2:0] S_WR_REQ  = BR_WR_REQ;
  localparam logic [2:0] S_WR_RESP = BR_WR_RESP;

  logic [2:0]  r_state;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_aw_done;
  logic        r_w_done;

  logic w_accept;
  logic w_arvalid;
  logic w_ar_hs;
  logic w_r_last_hs;
  logic w_awvalid;
  logic w_wvalid;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_wr_req_fin;
  logic w_b_hs;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_unused_ok;

  // Acceptance is gated by resetn so addr_ok is low for the whole reset.
  assign w_accept    = resetn & bus.data_req & (r_state == S_IDLE);

  assign w_arvalid   = (r_state == S_RD_ADDR);
  assign w_ar_hs     = w_arvalid & bus.arready;
  assign w_r_last_hs = (r_state == S_RD_DATA) & bus.rvalid & bus.rlast;

  // AW and W are independent: each drops after its own handshake, and the
  // request phase ends on the cycle the later of the two completes.
  assign w_awvalid    = (r_state == S_WR_REQ) & ~r_aw_done;
  assign w_wvalid     = (r_state == S_WR_REQ) & ~r_w_done;
  assign w_aw_hs      = w_awvalid & bus.awready;
  assign w_w_hs       = w_wvalid & bus.wready;
  assign w_wr_req_fin = (r_state == S_WR_REQ) & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_b_hs       = (r_state == S_WR_RESP) & bus.bvalid;

  assign w_rd_ok = w_r_last_hs;
`ifdef SRAMLIKE_AXI_WR_EARLY_OK_EN
  assign w_wr_ok = w_wr_req_fin;
`else
  assign w_wr_ok = w_b_hs;
`endif

  // Response IDs and error codes do not influence completion.
  assign w_unused_ok = ^{bus.rid, bus.rresp, bus.bid, bus.bresp};

  // sram-like side
  assign bus.data_addr_ok = w_accept;
  assign bus.data_data_ok = r_wr ? w_wr_ok : w_rd_ok;
  assign bus.data_rdata   = bus.rdata;

  // AR channel
  assign bus.arid    = ID_W'(RD_ID);
  assign bus.araddr  = r_addr;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, r_size};
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = w_arvalid;

  // R channel
  assign bus.rready = (r_state == S_RD_DATA);

  // AW channel
  assign bus.awid    = ID_W'(WR_ID);
  assign bus.awaddr  = r_addr;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = {1'b0, r_size};
  assign bus.awburst = AXI_BURST_INCR;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'b0000;
  assign bus.awprot  = 3'b000;
  assign bus.awvalid = w_awvalid;

  // W channel
  assign bus.wid    = ID_W'(WR_ID);
  assign bus.wdata  = r_wdata;
  assign bus.wstrb  = axi_wstrb(r_size, r_addr[1:0]);
  assign bus.wlast  = 1'b1;
  assign bus.wvalid = w_wvalid;

  // B channel
  assign bus.bready = (r_state == S_WR_RESP);

  // Request fields are captured only on acceptance, so a request presented
  // while busy cannot disturb the transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_wr      <= 1'b0;
      r_size    <= 2'b00;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr      <= bus.data_wr;
            r_size    <= bus.data_size;
            r_addr    <= bus.data_addr;
            r_wdata   <= bus.data_wdata;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= bus.data_wr ? S_WR_REQ : S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          if (w_ar_hs) r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (w_r_last_hs) r_state <= S_IDLE;
        end
        S_WR_REQ: begin
          if (w_aw_hs)      r_aw_done <= 1'b1;
          if (w_w_hs)       r_w_done  <= 1'b1;
          if (w_wr_req_fin) r_state   <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (w_b_hs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// ---------------------------------------------------------------------------
// tb_sramlike_axi_bridge
// Directed scenarios against sramlike_axi_bridge with a configurable AXI
// slave model and a scoreboard of expected data_data_ok completions.
// Honors SRAMLIKE_AXI_WR_EARLY_OK_EN to pick the expected write-ack timing.
// ---------------------------------------------------------------------------
module tb_sramlike_axi_bridge;
  import axi_pkg::*;

`ifdef SRAMLIKE_AXI_WR_EARLY_OK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sramlike_axi_bridge_if #(.ID_W(4)) bus ();

  sramlike_axi_bridge #(.ID_W(4), .RD_ID(0), .WR_ID(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] ar_addr_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ok_cnt = 0;
  int last_ok_cyc = 0;
  logic last_ok_bhs = 1'b0;
  logic last_ok_wrhs = 1'b0;

  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [7:0]  cap_arlen, cap_awlen;
  logic [1:0]  cap_arburst, cap_awburst;
  logic [3:0]  cap_arid, cap_awid, cap_wid, cap_wstrb;
  logic [8:0]  cap_arfix;
  logic        cap_wlast;

  // slave model configuration
  int          cfg_ar_dly = 0, cfg_r_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic        cfg_rd_xor = 1'b0;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  logic [3:0]  cfg_rid = 4'h0, cfg_bid = 4'h1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI slave channels: each ready/valid is updated just after the clock edge.
  initial begin
    int w;
    w = 0;
    bus.arready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.arvalid === 1'b1) begin
        if (w >= cfg_ar_dly) bus.arready = 1'b1;
        else begin bus.arready = 1'b0; w++; end
      end else begin bus.arready = 1'b0; w = 0; end
    end
  end

  initial begin
    int w;
    w = 0;
    bus.awready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.awvalid === 1'b1) begin
        if (w >= cfg_aw_dly) bus.awready = 1'b1;
        else begin bus.awready = 1'b0; w++; end
      end else begin bus.awready = 1'b0; w = 0; end
    end
  end

  initial begin
    int w;
    w = 0;
    bus.wready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.wvalid === 1'b1) begin
        if (w >= cfg_w_dly) bus.wready = 1'b1;
        else begin bus.wready = 1'b0; w++; end
      end else begin bus.wready = 1'b0; w = 0; end
    end
  end

  initial begin
    int w;
    w = 0;
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00; bus.rid = 4'h0;
    forever begin
      @(posedge clk); #1;
      if (bus.rready === 1'b1 && w >= cfg_r_dly) begin
        bus.rvalid = 1'b1; bus.rlast = 1'b1;
        bus.rdata  = cfg_rdata ^ (cfg_rd_xor ? cap_araddr : 32'h0);
        bus.rresp  = cfg_rresp; bus.rid = cfg_rid;
      end else begin
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        if (bus.rready === 1'b1) w++; else w = 0;
      end
    end
  end

  initial begin
    int w;
    w = 0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.bid = 4'h0;
    forever begin
      @(posedge clk); #1;
      if (bus.bready === 1'b1 && w >= cfg_b_dly) begin
        bus.bvalid = 1'b1; bus.bresp = cfg_bresp; bus.bid = cfg_bid;
      end else begin
        bus.bvalid = 1'b0;
        if (bus.bready === 1'b1) w++; else w = 0;
      end
    end
  end

  // Handshake capture and data_ok scoreboard, sampled mid-cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.arvalid === 1'b1 && bus.arready === 1'b1) begin
      ar_cnt++;
      cap_araddr = bus.araddr; cap_arsize = bus.arsize; cap_arlen = bus.arlen;
      cap_arburst = bus.arburst; cap_arid = bus.arid;
      cap_arfix = {bus.arlock, bus.arcache, bus.arprot};
      ar_addr_q.push_back(bus.araddr);
    end
    if (bus.rvalid === 1'b1 && bus.rready === 1'b1) r_cnt++;
    if (bus.awvalid === 1'b1 && bus.awready === 1'b1) begin
      aw_cnt++;
      cap_awaddr = bus.awaddr; cap_awsize = bus.awsize; cap_awlen = bus.awlen;
      cap_awburst = bus.awburst; cap_awid = bus.awid;
    end
    if (bus.wvalid === 1'b1 && bus.wready === 1'b1) begin
      w_cnt++;
      cap_wdata = bus.wdata; cap_wstrb = bus.wstrb; cap_wlast = bus.wlast; cap_wid = bus.wid;
    end
    if (bus.bvalid === 1'b1 && bus.bready === 1'b1) b_cnt++;
    if (bus.data_data_ok !== 1'b0) begin
      ok_cnt++;
      last_ok_cyc  = cyc;
      last_ok_bhs  = bus.bvalid & bus.bready;
      last_ok_wrhs = (bus.awvalid & bus.awready) | (bus.wvalid & bus.wready);
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_data_ok: got data_ok=%b with empty scoreboard at cycle %0d", bus.data_data_ok, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.rready !== e.is_rd || (e.is_rd && bus.data_rdata !== e.data)) begin
          n_fail++;
          $display("FAIL data_ok_payload: got rd=%b rdata=%h, required rd=%b rdata=%h",
                   bus.rready, bus.data_rdata, e.is_rd, e.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic is_rd, input logic [31:0] d);
    exp_t e;
    e.is_rd = is_rd; e.data = d;
    exp_q.push_back(e);
  endtask

  // Presents one request and holds it until accepted or budget runs out.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output bit acc);
    acc = 1'b0;
    @(posedge clk); #1;
    bus.data_req = 1'b1; bus.data_wr = wr; bus.data_size = sz;
    bus.data_addr = a; bus.data_wdata = wd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.data_addr_ok === 1'b1) begin acc = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.data_req = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, output bit quiet);
    quiet = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 &&
          {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.data_data_ok} === 6'b0) begin
        quiet = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = SRAM_SIZE_WORD;
    bus.data_addr = 32'h1234_5678; bus.data_wdata = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (bus.data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ok: got %b required 0", bus.data_addr_ok); end
    n_chk++;
    if (bus.data_data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok: got %b required 0", bus.data_data_ok); end
    n_chk++;
    if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_handshakes: got %b required 00000",
               {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready});
    end
    n_chk++;
    if (bus.araddr !== 32'h0 || bus.wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_latched: got addr=%h wdata=%h required 0", bus.araddr, bus.wdata);
    end
    @(posedge clk); #1;
    bus.data_req = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic test_read();
    int ok0, ar0;
    bit acc, quiet;
    cfg_ar_dly = 2; cfg_r_dly = 3; cfg_rdata = 32'hDEAD_BEEF; cfg_rd_xor = 1'b0;
    cfg_rresp = AXI_RESP_OKAY; cfg_rid = 4'h0;
    ok0 = ok_cnt; ar0 = ar_cnt;
    push_exp(1'b1, 32'hDEAD_BEEF);
    issue(1'b0, SRAM_SIZE_WORD, 32'h1000_0004, 32'h0, acc);
    n_chk++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL read_accept: got %b required 1", acc); end
    wait_quiet(60, quiet);
    n_chk++;
    if (quiet !== 1'b1) begin n_fail++; $display("FAIL read_timeout: got quiet=%b required 1", quiet); end
    n_chk++;
    if (ar_cnt - ar0 !== 1) begin n_fail++; $display("FAIL read_ar_count: got %0d required 1", ar_cnt - ar0); end
    n_chk++;
    if ({cap_araddr, cap_arsize, cap_arlen, cap_arburst, cap_arid, cap_arfix} !==
        {32'h1000_0004, 3'b010, 8'd0, 2'b01, 4'h0, 9'h0}) begin
      n_fail++;
      $display("FAIL read_ar_fields: got addr=%h size=%b len=%0d burst=%b id=%h fix=%h required 10000004 010 0 01 0 0",
               cap_araddr, cap_arsize, cap_arlen, cap_arburst, cap_arid, cap_arfix);
    end
    n_chk++;
    if (ok_cnt - ok0 !== 1) begin n_fail++; $display("FAIL read_ok_count: got %0d required 1", ok_cnt - ok0); end
  endtask

  task automatic test_byte_write();
    int ok0, aw0, w0, b0;
    bit acc, quiet;
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 2; cfg_bresp = AXI_RESP_OKAY; cfg_bid = 4'h1;
    ok0 = ok_cnt; aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    push_exp(1'b0, 32'h0);
    issue(1'b1, SRAM_SIZE_BYTE, 32'h0000_0003, 32'h0000_00AA, acc);
    n_chk++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL bw_accept: got %b required 1", acc); end
    wait_quiet(60, quiet);
    n_chk++;
    if (quiet !== 1'b1) begin n_fail++; $display("FAIL bw_timeout: got quiet=%b required 1", quiet); end
    n_chk++;
    if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL bw_hs_counts: got aw=%0d w=%0d b=%0d required 1 1 1", aw_cnt - aw0, w_cnt - w0, b_cnt - b0);
    end
    n_chk++;
    if ({cap_wstrb, cap_wlast, cap_wdata, cap_wid} !== {4'b1000, 1'b1, 32'h0000_00AA, 4'h1}) begin
      n_fail++; $display("FAIL bw_w_fields: got strb=%b last=%b data=%h wid=%h required 1000 1 000000aa 1",
                         cap_wstrb, cap_wlast, cap_wdata, cap_wid);
    end
    n_chk++;
    if ({cap_awaddr, cap_awsize, cap_awlen, cap_awburst, cap_awid} !== {32'h3, 3'b000, 8'd0, 2'b01, 4'h1}) begin
      n_fail++; $display("FAIL bw_aw_fields: got addr=%h size=%b len=%0d burst=%b id=%h required 3 000 0 01 1",
                         cap_awaddr, cap_awsize, cap_awlen, cap_awburst, cap_awid);
    end
    n_chk++;
    if (ok_cnt - ok0 !== 1) begin n_fail++; $display("FAIL bw_ok_count: got %0d required 1", ok_cnt - ok0); end
    n_chk++;
    if (last_ok_bhs !== !EARLY) begin n_fail++; $display("FAIL bw_ok_on_b: got %b required %b", last_ok_bhs, !EARLY); end
    n_chk++;
    if (last_ok_wrhs !== EARLY) begin n_fail++; $display("FAIL bw_ok_on_awhs: got %b required %b", last_ok_wrhs, EARLY); end
  endtask

  task automatic test_half_write();
    int ok0, aw0, w0, b0;
    bit acc, quiet, pend, seen;
    cfg_aw_dly = 4; cfg_w_dly = 0; cfg_b_dly = 1;
    ok0 = ok_cnt; aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    pend = 1'b0; seen = 1'b0;
    push_exp(1'b0, 32'h0);
    issue(1'b1, SRAM_SIZE_HALF, 32'h0000_0102, 32'h1234_5678, acc);
    n_chk++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL hw_accept: got %b required 1", acc); end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (pend) begin
        seen = 1'b1;
        n_chk++;
        if ({bus.wvalid, bus.awvalid} !== 2'b01) begin
          n_fail++; $display("FAIL hw_w_drop: got wvalid=%b awvalid=%b required 0 1", bus.wvalid, bus.awvalid);
        end
      end else if (bus.wvalid === 1'b1 && bus.wready === 1'b1 && bus.awready !== 1'b1) begin
        pend = 1'b1;
      end
    end
    n_chk++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL hw_w_first: got seen=%b required 1", seen); end
    wait_quiet(60, quiet);
    n_chk++;
    if (quiet !== 1'b1) begin n_fail++; $display("FAIL hw_timeout: got quiet=%b required 1", quiet); end
    n_chk++;
    if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0, ok_cnt - ok0} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL hw_counts: got aw=%0d w=%0d b=%0d ok=%0d required 1 1 1 1",
                         aw_cnt - aw0, w_cnt - w0, b_cnt - b0, ok_cnt - ok0);
    end
    n_chk++;
    if ({cap_wstrb, cap_wdata, cap_awsize} !== {4'b1100, 32'h1234_5678, 3'b001}) begin
      n_fail++; $display("FAIL hw_fields: got strb=%b data=%h size=%b required 1100 12345678 001",
                         cap_wstrb, cap_wdata, cap_awsize);
    end
    n_chk++;
    if (last_ok_bhs !== !EARLY) begin n_fail++; $display("FAIL hw_ok_on_b: got %b required %b", last_ok_bhs, !EARLY); end
  endtask

  task automatic test_back_to_back();
    int ok0, acc2_cyc;
    bit got1, got2, quiet;
    logic [31:0] a1, a2, q1, q2;
    a1 = 32'h0000_0100; a2 = 32'h0000_0200;
    cfg_ar_dly = 0; cfg_r_dly = 3; cfg_rdata = 32'hA5A5_0000; cfg_rd_xor = 1'b1;
    ok0 = ok_cnt; got1 = 1'b0; got2 = 1'b0; acc2_cyc = 0;
    push_exp(1'b1, 32'hA5A5_0000 ^ a1);
    push_exp(1'b1, 32'hA5A5_0000 ^ a2);
    while (ar_addr_q.size() > 0) void'(ar_addr_q.pop_front());
    @(posedge clk); #1;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = SRAM_SIZE_WORD;
    bus.data_addr = a1; bus.data_wdata = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.data_addr_ok === 1'b1) begin got1 = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.data_addr = a2;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.data_addr_ok === 1'b1) begin got2 = 1'b1; acc2_cyc = cyc; break; end
    end
    @(posedge clk); #1;
    bus.data_req = 1'b0;
    n_chk++;
    if ({got1, got2} !== 2'b11) begin n_fail++; $display("FAIL b2b_accepts: got %b required 11", {got1, got2}); end
    n_chk++;
    if (acc2_cyc !== last_ok_cyc + 1) begin
      n_fail++; $display("FAIL b2b_accept_cycle: got %0d required %0d", acc2_cyc, last_ok_cyc + 1);
    end
    wait_quiet(60, quiet);
    n_chk++;
    if (quiet !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got quiet=%b required 1", quiet); end
    q1 = (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hFFFF_FFFF;
    q2 = (ar_addr_q.size() > 1) ? ar_addr_q[1] : 32'hFFFF_FFFF;
    n_chk++;
    if ({q1, q2, ok_cnt - ok0} !== {a1, a2, 32'd2}) begin
      n_fail++; $display("FAIL b2b_addrs: got %h %h ok=%0d required %h %h 2", q1, q2, ok_cnt - ok0, a1, a2);
    end
    cfg_rd_xor = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ok0;
    bit acc, quiet, seen;
    cfg_ar_dly = 0; cfg_r_dly = 20; cfg_rdata = 32'h1111_2222;
    ok0 = ok_cnt; seen = 1'b0;
    issue(1'b0, SRAM_SIZE_WORD, 32'h0000_0040, 32'h0, acc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rready === 1'b1) begin seen = 1'b1; break; end
    end
    n_chk++;
    if ({acc, seen} !== 2'b11) begin n_fail++; $display("FAIL rm_reach_rdata: got %b required 11", {acc, seen}); end
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    n_chk++;
    if ({bus.rready, bus.arvalid, bus.data_data_ok, bus.data_addr_ok} !== 4'b0) begin
      n_fail++; $display("FAIL rm_async_drop: got %b required 0000",
                         {bus.rready, bus.arvalid, bus.data_data_ok, bus.data_addr_ok});
    end
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    n_chk++;
    if (ok_cnt !== ok0) begin n_fail++; $display("FAIL rm_no_ok: got %0d required %0d", ok_cnt, ok0); end
    cfg_r_dly = 1;
    push_exp(1'b1, 32'h1111_2222);
    issue(1'b0, SRAM_SIZE_WORD, 32'h0000_0044, 32'h0, acc);
    wait_quiet(60, quiet);
    n_chk++;
    if ({acc, quiet, cap_araddr, ok_cnt - ok0} !== {1'b1, 1'b1, 32'h44, 32'd1}) begin
      n_fail++; $display("FAIL rm_fresh_read: got acc=%b quiet=%b addr=%h ok=%0d required 1 1 44 1",
                         acc, quiet, cap_araddr, ok_cnt - ok0);
    end
  endtask

  task automatic test_slverr();
    int ok0;
    bit acc, quiet;
    cfg_aw_dly = 1; cfg_w_dly = 2; cfg_b_dly = 2; cfg_bresp = AXI_RESP_SLVERR; cfg_bid = 4'h9;
    ok0 = ok_cnt;
    push_exp(1'b0, 32'h0);
    issue(1'b1, SRAM_SIZE_WORD, 32'h0000_0020, 32'h89AB_CDEF, acc);
    wait_quiet(60, quiet);
    n_chk++;
    if ({acc, quiet, ok_cnt - ok0} !== {1'b1, 1'b1, 32'd1}) begin
      n_fail++; $display("FAIL slverr_write: got acc=%b quiet=%b ok=%0d required 1 1 1", acc, quiet, ok_cnt - ok0);
    end
    n_chk++;
    if (cap_wstrb !== 4'b1111) begin n_fail++; $display("FAIL slverr_wstrb: got %b required 1111", cap_wstrb); end
    cfg_r_dly = 0; cfg_rresp = AXI_RESP_DECERR; cfg_rid = 4'h7; cfg_rdata = 32'h0BAD_0BAD;
    ok0 = ok_cnt;
    push_exp(1'b1, 32'h0BAD_0BAD);
    issue(1'b0, SRAM_SIZE_WORD, 32'h0000_0030, 32'h0, acc);
    wait_quiet(60, quiet);
    n_chk++;
    if ({acc, quiet, ok_cnt - ok0} !== {1'b1, 1'b1, 32'd1}) begin
      n_fail++; $display("FAIL decerr_read: got acc=%b quiet=%b ok=%0d required 1 1 1", acc, quiet, ok_cnt - ok0);
    end
    cfg_bresp = AXI_RESP_OKAY; cfg_rresp = AXI_RESP_OKAY;
  endtask

  initial begin
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'b00;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
    test_reset();
    test_read();
    test_byte_write();
    test_half_write();
    test_back_to_back();
    test_reset_mid();
    test_slverr();
    repeat (3) @(posedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
